alu_ex_stage: RTL and testbench
===============================

ALU_EX_STAGE -- requirements
Module: alu_ex_stage

Interface
REQ-001 The block SHALL take parameter: WIDTH, 32, datapath width (only 32 is supported).
REQ-002 The block SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 The block SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 The block SHALL have port: in_valid  input  1  operand bundle valid.
REQ-005 The block SHALL have port: in_ready  output  1  stage can accept a bundle.
REQ-006 The block SHALL have port: in_a  input  32  operand A (value shifted for shift ops).
REQ-007 The block SHALL have port: in_b  input  32  operand B (shift amount for shift ops).
REQ-008 The block SHALL have port: in_op  input  4  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR, 6 SLL, 7 SRL, 8 SRA, 9 SLT; 10-15 illegal.
REQ-009 The block SHALL have port: out_valid  output  1  result bundle valid.
REQ-010 The block SHALL have port: out_ready  input  1  downstream accepts result.
REQ-011 The block SHALL have port: out_result  output  32  registered result.
REQ-012 The block SHALL have port: out_flags  output  4  registered {N,Z,C,V}.

Function
REQ-013 Transfers SHALL occur only on cycles where valid and ready are both high, at each port.
REQ-014 Latency SHALL be exactly 1 cycle: a bundle accepted at edge k SHALL be presented on out_* after edge k when out_valid was low or the output was being accepted that same cycle.
REQ-015 The block SHALL sustain one accepted bundle per cycle while out_ready is held high.
REQ-016 Storage SHALL be an output register plus a one-entry skid register, giving states EMPTY, ONE, FULL.
REQ-017 In EMPTY, an accept SHALL go to ONE.
REQ-018 In ONE, accept with no drain SHALL go to FULL (new bundle into skid), drain with no accept SHALL go to EMPTY, and accept with drain SHALL stay ONE.
REQ-019 In FULL, a drain SHALL move the skid entry to the output register and go to ONE.
REQ-020 in_ready SHALL be a registered signal, high exactly when state is not FULL.
REQ-021 out_valid SHALL be high exactly when state is ONE or FULL.
REQ-022 Ordering SHALL be preserved: the skid entry is always older-than-none-after the output entry.
REQ-023 out_result and out_flags SHALL remain stable while out_valid is high and out_ready is low.
REQ-024 ADD/SUB SHALL operate modulo 2^32; C = carry-out (ADD) or no-borrow, i.e. A>=B unsigned (SUB); V = signed overflow.
REQ-025 For shifts, amount = in_b[4:0]; if any of in_b[31:5] is set, SLL/SRL SHALL give 0 and SRA SHALL give 32 copies of in_a[31].
REQ-026 For shift amounts 1..31, C SHALL be the last bit shifted out; for amount 0 or out-of-range, C = 0.
REQ-027 SLT SHALL give 1 if A<B signed, else 0.
REQ-028 Logic ops and SLT SHALL force C=0 and V=0, as do shifts for V.
REQ-029 For all ops, N = result[31] and Z = (result == 0).
REQ-030 An illegal opcode SHALL give result 0 and flags {0,1,0,0}.

Reset
REQ-031 While rst_n is low at a rising edge, state SHALL become EMPTY and in_ready SHALL become 1.
REQ-032 During reset, out_valid, out_result and out_flags SHALL be 0.
REQ-033 A reset mid-operation SHALL discard any held bundles without emitting them.
REQ-034 During the reset cycle itself, in_valid SHALL be ignored.

Structure
REQ-035 Opcode constants, the flag bit positions and the state encoding SHALL live in the shared alu_pkg package.
REQ-036 Result and flag computation SHALL be a single combinational sub-module, alu32_core.
REQ-037 alu_ex_stage SHALL contain only the handshake/skid logic and registers.

Verification
REQ-038 Directed: SLL A=0x0000_0001, B=31 -> result 0x8000_0000, flags N=1 Z=0 C=0 V=0.
REQ-039 Directed: SLL A=0xFFFF_FFFF, B=0x0000_0020 -> result 0, Z=1. Same inputs with SRA -> result 0xFFFF_FFFF, N=1.
REQ-040 Directed: ADD 0x7FFF_FFFF+1 -> result 0x8000_0000, V=1, C=0. SUB 5-5 -> result 0, Z=1, C=1.
REQ-041 Directed: out_ready low, three back-to-back valid bundles -> two accepted, in_ready low after the second. Raise out_ready -> results emerge in order, no loss or duplicate.
REQ-042 Directed: rst_n low for one cycle while FULL -> out_valid=0 and in_ready=1 next cycle; no stale result appears later.
REQ-043 Directed: in_op=12 -> result 0, flags 4'b0100. A continuous stream with out_ready=1 -> one result per cycle, 1-cycle latency.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, flag bit positions, skid state encoding
// and the registered result bundle.
package alu_pkg;

   localparam int XLEN = 32;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_NOR = 4'd5;
   localparam logic [3:0] OP_SLL = 4'd6;
   localparam logic [3:0] OP_SRL = 4'd7;
   localparam logic [3:0] OP_SRA = 4'd8;
   localparam logic [3:0] OP_SLT = 4'd9;

   // Flags are packed as {N,Z,C,V}
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } skid_state_e;

   typedef struct packed {
      logic [XLEN-1:0] result;
      logic [3:0]      flags;
   } alu_res_t;

   function automatic logic [3:0] make_flags(input logic [XLEN-1:0] r,
                                             input logic            c,
                                             input logic            v);
      logic [3:0] f;
      f         = '0;
      f[FLAG_N] = r[XLEN-1];
      f[FLAG_Z] = (r == '0);
      f[FLAG_C] = c;
      f[FLAG_V] = v;
      return f;
   endfunction

endpackage

// File: rtl/alu32_core.sv
// Purely combinational 32-bit ALU: result plus {N,Z,C,V} for one operand bundle.
// Illegal opcodes yield a zero result, which naturally produces flags 4'b0100.
module alu32_core
   import alu_pkg::*;
(
   input  logic [3:0]      op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output alu_res_t        res_o
);

   logic [XLEN:0]        sum_w;
   logic [XLEN-1:0]      diff_w;
   logic [XLEN:0]        sll_w;
   logic [XLEN:0]        srl_w;
   logic [XLEN:0]        sra_w;
   logic signed [XLEN:0] a_ext_s;
   logic [4:0]           shamt;
   logic                 shift_oor;
   logic                 a_ge_b;
   logic                 a_lt_b_s;

   logic [XLEN-1:0]      result;
   logic                 carry;
   logic                 ovf;

   assign sum_w     = {1'b0, a_i} + {1'b0, b_i};
   assign diff_w    = a_i - b_i;
   assign shamt     = b_i[4:0];
   assign shift_oor = |b_i[XLEN-1:5];
   assign a_ge_b    = (a_i >= b_i);
   assign a_lt_b_s  = ($signed(a_i) < $signed(b_i));

   // One extra bit on the exit side of each shift catches the last bit
   // shifted out; a zero amount leaves that bit 0, so C=0 falls out for free.
   assign sll_w   = {1'b0, a_i} << shamt;
   assign srl_w   = {a_i, 1'b0} >> shamt;
   assign a_ext_s = {a_i, 1'b0};
   assign sra_w   = a_ext_s >>> shamt;

   always_comb begin
      result = '0;
      carry  = 1'b0;
      ovf    = 1'b0;
      case (op_i)
         OP_ADD: begin
            result = sum_w[XLEN-1:0];
            carry  = sum_w[XLEN];
            ovf    = (a_i[XLEN-1] == b_i[XLEN-1]) && (sum_w[XLEN-1] != a_i[XLEN-1]);
         end
         OP_SUB: begin
            result = diff_w;
            carry  = a_ge_b;
            ovf    = (a_i[XLEN-1] != b_i[XLEN-1]) && (diff_w[XLEN-1] != a_i[XLEN-1]);
         end
         OP_AND: result = a_i & b_i;
         OP_OR:  result = a_i | b_i;
         OP_XOR: result = a_i ^ b_i;
         OP_NOR: result = ~(a_i | b_i);
         OP_SLL: begin
            if (!shift_oor) begin
               result = sll_w[XLEN-1:0];
               carry  = sll_w[XLEN];
            end
         end
         OP_SRL: begin
            if (!shift_oor) begin
               result = srl_w[XLEN:1];
               carry  = srl_w[0];
            end
         end
         OP_SRA: begin
            if (shift_oor) begin
               result = {XLEN{a_i[XLEN-1]}};
            end else begin
               result = sra_w[XLEN:1];
               carry  = sra_w[0];
            end
         end
         OP_SLT: result = {{(XLEN-1){1'b0}}, a_lt_b_s};
         default: begin
            result = '0;
         end
      endcase
   end

   assign res_o.result = result;
   assign res_o.flags  = make_flags(result, carry, ovf);

endmodule

// File: rtl/alu_ex_stage.sv
// ALU execute stage: 1-cycle latency, output register plus one-entry skid so
// in_ready can be registered while still sustaining one bundle per cycle.
module alu_ex_stage
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [3:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [3:0]       out_flags
);

   alu_res_t    new_res;
   alu_res_t    out_q, out_d;
   alu_res_t    skid_q, skid_d;
   skid_state_e state_q, state_d;
   logic        in_ready_q;
   logic        accept;
   logic        drain;

   alu32_core u_core (
      .op_i  (in_op),
      .a_i   (in_a),
      .b_i   (in_b),
      .res_o (new_res)
   );

   assign accept = in_valid && in_ready_q;
   assign drain  = (state_q != ST_EMPTY) && out_ready;

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      skid_d  = skid_q;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               out_d   = new_res;
               state_d = ST_ONE;
            end
         end
         ST_ONE: begin
            if (accept && drain) begin
               out_d = new_res;
            end else if (accept) begin
               skid_d  = new_res;
               state_d = ST_FULL;
            end else if (drain) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            // in_ready is low here, so only a drain can happen
            if (drain) begin
               out_d   = skid_q;
               state_d = ST_ONE;
            end
         end
         default: begin
            state_d = ST_EMPTY;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_EMPTY;
         in_ready_q <= 1'b1;
         out_q      <= '0;
         skid_q     <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != ST_FULL);
         out_q      <= out_d;
         skid_q     <= skid_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = (state_q == ST_ONE) || (state_q == ST_FULL);
   assign out_result = out_q.result;
   assign out_flags  = out_q.flags;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Directed bench for alu_ex_stage: ALU vectors, skid backpressure, reset and streaming.
module tb_alu_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_a;
   logic [31:0] in_b;
   logic [3:0]  in_op;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [3:0]  out_flags;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [3:0]  fl;
   } vec_t;

   alu_ex_stage #(.WIDTH(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_op      (in_op),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_flags  (out_flags)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b);
      in_valid = v;
      in_op    = op;
      in_a     = a;
      in_b     = b;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      out_ready = 1'b0;
      drive(1'b1, 4'd0, 32'd3, 32'd4);
      step();
      step();
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      n_checks++;
      if (out_result !== 32'd0) begin n_fail++; $display("FAIL reset_out_result got %h want 0", out_result); end
      n_checks++;
      if (out_flags !== 4'd0) begin n_fail++; $display("FAIL reset_out_flags got %b want 0000", out_flags); end
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      rst_n = 1'b1;
      step();
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release_valid got %b want 0", out_valid); end
   endtask

   // Each vector is accepted and checked on the very next edge, with the
   // previous result draining on the same edge.
   task automatic run_vectors(input string tag, input vec_t v[]);
      out_ready = 1'b1;
      foreach (v[i]) begin
         drive(1'b1, v[i].op, v[i].a, v[i].b);
         step();
         n_checks++;
         if (out_valid !== 1'b1 || out_result !== v[i].res || out_flags !== v[i].fl) begin
            n_fail++;
            $display("FAIL %s[%0d] got v=%b r=%h f=%b want v=1 r=%h f=%b",
                     tag, i, out_valid, out_result, out_flags, v[i].res, v[i].fl);
         end
      end
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      step();
   endtask

   task automatic test_shift();
      vec_t v[] = new[7];
      v[0] = '{4'd6, 32'h0000_0001, 32'd31,        32'h8000_0000, 4'b1000};
      v[1] = '{4'd6, 32'hFFFF_FFFF, 32'h0000_0020, 32'h0000_0000, 4'b0100};
      v[2] = '{4'd8, 32'hFFFF_FFFF, 32'h0000_0020, 32'hFFFF_FFFF, 4'b1000};
      v[3] = '{4'd7, 32'h8000_0001, 32'd1,         32'h4000_0000, 4'b0010};
      v[4] = '{4'd6, 32'hFFFF_FFFF, 32'd0,         32'hFFFF_FFFF, 4'b1000};
      v[5] = '{4'd8, 32'h8000_0000, 32'd4,         32'hF800_0000, 4'b1000};
      v[6] = '{4'd6, 32'h4000_0000, 32'd2,         32'h0000_0000, 4'b0110};
      run_vectors("shift", v);
   endtask

   task automatic test_arith();
      vec_t v[] = new[5];
      v[0] = '{4'd0, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 4'b1001};
      v[1] = '{4'd1, 32'd5,         32'd5,         32'h0000_0000, 4'b0110};
      v[2] = '{4'd0, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 4'b0110};
      v[3] = '{4'd1, 32'd3,         32'd5,         32'hFFFF_FFFE, 4'b1000};
      v[4] = '{4'd1, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 4'b0011};
      run_vectors("arith", v);
   endtask

   task automatic test_logic();
      vec_t v[] = new[6];
      v[0] = '{4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 4'b1000};
      v[1] = '{4'd3, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 4'b0100};
      v[2] = '{4'd4, 32'hAAAA_AAAA, 32'h5555_5555, 32'hFFFF_FFFF, 4'b1000};
      v[3] = '{4'd5, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 4'b1000};
      v[4] = '{4'd9, 32'hFFFF_FFFF, 32'd1,         32'h0000_0001, 4'b0000};
      v[5] = '{4'd9, 32'd1,         32'hFFFF_FFFF, 32'h0000_0000, 4'b0100};
      run_vectors("logic", v);
   endtask

   task automatic test_illegal();
      vec_t v[] = new[2];
      v[0] = '{4'd12, 32'd5,         32'd7,         32'h0000_0000, 4'b0100};
      v[1] = '{4'd15, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 4'b0100};
      run_vectors("illegal", v);
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      drive(1'b1, 4'd0, 32'd1, 32'd2);        // X = 3
      step();
      drive(1'b1, 4'd0, 32'd10, 32'd20);      // Y = 30
      step();
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_full got %b want 0", in_ready); end
      drive(1'b1, 4'd0, 32'd100, 32'd200);    // Z = 300, must be refused
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_result !== 32'd3) begin
         n_fail++; $display("FAIL bp_hold got v=%b r=%h want v=1 r=3", out_valid, out_result);
      end
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_still_full got %b want 0", in_ready); end
      out_ready = 1'b1;
      step();
      n_checks++;
      if (out_valid !== 1'b1 || out_result !== 32'd30 || in_ready !== 1'b1) begin
         n_fail++; $display("FAIL bp_second got v=%b r=%h rdy=%b want v=1 r=1e rdy=1", out_valid, out_result, in_ready);
      end
      step();
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      n_checks++;
      if (out_valid !== 1'b1 || out_result !== 32'd300) begin
         n_fail++; $display("FAIL bp_third got v=%b r=%h want v=1 r=12c", out_valid, out_result);
      end
      step();
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got %b want 0", out_valid); end
   endtask

   task automatic test_reset_full();
      out_ready = 1'b0;
      drive(1'b1, 4'd0, 32'd7, 32'd0);
      step();
      drive(1'b1, 4'd0, 32'd8, 32'd0);
      step();
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rf_full got in_ready=%b want 0", in_ready); end
      rst_n = 1'b0;
      drive(1'b1, 4'd0, 32'd9, 32'd0);
      step();
      rst_n = 1'b1;
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 32'd0) begin
         n_fail++; $display("FAIL rf_after_reset got v=%b rdy=%b r=%h want v=0 rdy=1 r=0", out_valid, in_ready, out_result);
      end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         n_checks++;
         if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rf_stale[%0d] got v=%b r=%h want v=0", i, out_valid, out_result);
         end
      end
   endtask

   task automatic test_stream();
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, 4'd0, 32'(i), 32'(i * 16));
         n_checks++;
         if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_rdy[%0d] got %b want 1", i, in_ready); end
         step();
         n_checks++;
         if (out_valid !== 1'b1 || out_result !== 32'(i * 17)) begin
            n_fail++; $display("FAIL stream[%0d] got v=%b r=%h want v=1 r=%h", i, out_valid, out_result, 32'(i * 17));
         end
      end
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      step();
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_end got %b want 0", out_valid); end
   endtask

   initial begin
      rst_n     = 1'b0;
      out_ready = 1'b0;
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      test_reset();
      test_shift();
      test_arith();
      test_logic();
      test_illegal();
      test_backpressure();
      test_reset_full();
      test_stream();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
